// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache/main-memory arbiter: FSM states, requester ids,
// and the default block-fill length.
package wisc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;

  localparam int BLOCK_WORDS = 8;

endpackage

// File: rtl/cache_mem_arbiter_beat_counter.sv
// Counts returned memory beats within one block fill and flags the final beat.
module mem_beat_counter #(
  parameter  int BLOCK_WORDS = 8,
  localparam int CW          = $clog2(BLOCK_WORDS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Natural wrap on the final beat leaves the counter at 0 for the next fill.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CW'(BLOCK_WORDS - 1));

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing the main-memory port between the I-cache and
// D-cache fill FSMs; one block fill or one single-word write per grant.
module cache_mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_grant,
  output logic              ic_data_valid,
  input  logic              dc_req,
  input  logic              dc_wr,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_grant,
  output logic              dc_data_valid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_data_valid
);

  import wisc_mem_pkg::*;

  arb_state_t state_q, state_d;
  requester_t last_grant_q, last_grant_d;
  logic       op_wr_q, op_wr_d;

  logic beat_clr;
  logic beat_en;
  logic beat_last;
  logic beat_done;

  // Beats are only counted for read ops; valids seen in IDLE are dropped.
  assign beat_clr  = (state_q == IDLE);
  assign beat_en   = mem_data_valid &&
                     ((state_q == GNT_I) || ((state_q == GNT_D) && !op_wr_q));
  assign beat_done = beat_en && beat_last;

  mem_beat_counter #(
    .BLOCK_WORDS (BLOCK_WORDS)
  ) u_beat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (beat_clr),
    .en    (beat_en),
    .last  (beat_last)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_wr_d      = op_wr_q;
    case (state_q)
      IDLE: begin
        // On a tie, the requester that did not win last time goes first.
        if (ic_req && (!dc_req || (last_grant_q == REQ_D))) begin
          state_d      = GNT_I;
          last_grant_d = REQ_I;
          op_wr_d      = 1'b0;
        end else if (dc_req) begin
          state_d      = GNT_D;
          last_grant_d = REQ_D;
          op_wr_d      = dc_wr;
        end
      end
      GNT_I: begin
        if (beat_done) state_d = IDLE;
      end
      GNT_D: begin
        if (op_wr_q || beat_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_I;
      op_wr_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_wr_q      <= op_wr_d;
    end
  end

  assign ic_grant      = (state_q == GNT_I);
  assign dc_grant      = (state_q == GNT_D);
  assign ic_data_valid = ic_grant && mem_data_valid;
  assign dc_data_valid = dc_grant && mem_data_valid;
  assign mem_rdata     = mem_data_out;

  // mem_enable follows req during reads, so a dropped req stops new issues
  // while the grant is still held to drain outstanding beats.
  always_comb begin
    mem_enable = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      GNT_I: begin
        mem_enable = ic_req;
        mem_addr   = ic_addr;
      end
      GNT_D: begin
        mem_addr = dc_addr;
        if (op_wr_q) begin
          mem_enable = 1'b1;
          mem_wr     = 1'b1;
          mem_wdata  = dc_wdata;
        end else begin
          mem_enable = dc_req;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a read-data scoreboard.
module tb_cache_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ic_req;
  logic [15:0] ic_addr;
  logic        ic_grant;
  logic        ic_data_valid;
  logic        dc_req;
  logic        dc_wr;
  logic [15:0] dc_addr;
  logic [15:0] dc_wdata;
  logic        dc_grant;
  logic        dc_data_valid;
  logic [15:0] mem_rdata;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_data_out;
  logic        mem_data_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_d;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];

  cache_mem_arbiter #(
    .ADDR_W      (16),
    .DATA_W      (16),
    .BLOCK_WORDS (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ic_req         (ic_req),
    .ic_addr        (ic_addr),
    .ic_grant       (ic_grant),
    .ic_data_valid  (ic_data_valid),
    .dc_req         (dc_req),
    .dc_wr          (dc_wr),
    .dc_addr        (dc_addr),
    .dc_wdata       (dc_wdata),
    .dc_grant       (dc_grant),
    .dc_data_valid  (dc_data_valid),
    .mem_rdata      (mem_rdata),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_data_out   (mem_data_out),
    .mem_data_valid (mem_data_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every forwarded data_valid must match the oldest pushed beat.
  always @(negedge clk) begin
    if (ic_data_valid || dc_data_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", {30'd0, ic_data_valid, dc_data_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("dv_route", {30'd0, ic_data_valid, dc_data_valid},
            e.is_d ? 32'd1 : 32'd2);
        chk("rdata", mem_rdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Drives n read beats to the granted requester and queues the expected data.
  task automatic beats(input int n, input int first, input bit is_d);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      mem_data_valid = 1'b1;
      mem_data_out   = is_d ? 16'(16'hD000 + first + i) : 16'(16'h1111 * (first + i + 1));
      e.is_d = is_d;
      e.data = mem_data_out;
      sb.push_back(e);
      if (is_d) begin
        dc_addr = 16'(16'h0200 + first + i);
        #1 chk("mem_addr_d", mem_addr, dc_addr);
        chk("ic_grant_held_off", ic_grant, 1'b0);
      end else begin
        ic_addr = 16'(16'h0100 + first + i);
        #1 chk("mem_addr_i", mem_addr, ic_addr);
        chk("dc_grant_held_off", dc_grant, 1'b0);
        chk("mem_wr_read", mem_wr, 1'b0);
        chk("mem_wdata_read", mem_wdata, 16'h0000);
      end
      tick();
    end
    mem_data_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ic_req = 1'b0; ic_addr = '0;
    dc_req = 1'b0; dc_wr = 1'b0; dc_addr = '0; dc_wdata = '0;
    mem_data_out = '0; mem_data_valid = 1'b0;
    tick();
    chk("rst_ic_grant", ic_grant, 1'b0);
    chk("rst_dc_grant", dc_grant, 1'b0);
    chk("rst_mem_enable", mem_enable, 1'b0);
    chk("rst_mem_wr", mem_wr, 1'b0);
    tick();
    rst_n = 1'b1;

    // Lone I-cache fill
    ic_req = 1'b1; ic_addr = 16'h0100;
    #1 chk("ic_grant_lat0", ic_grant, 1'b0);
    tick();
    chk("ic_grant_lat1", ic_grant, 1'b1);
    chk("ic_mem_enable", mem_enable, 1'b1);
    beats(8, 0, 1'b0);
    chk("ic_fill_done", ic_grant, 1'b0);
    ic_req = 1'b0;
    #1 chk("idle_mem_enable", mem_enable, 1'b0);
    chk("idle_mem_addr", mem_addr, 16'h0000);
    tick();

    // First tie after reset goes to D; I waits through the fill
    do_reset();
    ic_req = 1'b1; dc_req = 1'b1; dc_wr = 1'b0;
    tick();
    chk("tie1_dc_grant", dc_grant, 1'b1);
    chk("tie1_ic_grant", ic_grant, 1'b0);
    beats(8, 0, 1'b1);
    chk("tie1_idle_dc", dc_grant, 1'b0);
    chk("tie1_idle_ic", ic_grant, 1'b0);
    tick();
    chk("tie2_ic_grant", ic_grant, 1'b1);
    chk("tie2_dc_grant", dc_grant, 1'b0);

    // D write request arrives during the I fill and waits
    dc_wr = 1'b1; dc_addr = 16'h1234; dc_wdata = 16'hBEEF;
    beats(8, 0, 1'b0);
    ic_req = 1'b0;
    chk("post_fill_dc_idle", dc_grant, 1'b0);
    tick();
    chk("wr_dc_grant", dc_grant, 1'b1);
    chk("wr_mem_enable", mem_enable, 1'b1);
    chk("wr_mem_wr", mem_wr, 1'b1);
    chk("wr_mem_addr", mem_addr, 16'h1234);
    chk("wr_mem_wdata", mem_wdata, 16'hBEEF);
    dc_req = 1'b0; dc_wr = 1'b0;
    tick();
    chk("wr_done_grant", dc_grant, 1'b0);
    chk("wr_done_enable", mem_enable, 1'b0);
    chk("wr_done_wr", mem_wr, 1'b0);
    chk("wr_done_wdata", mem_wdata, 16'h0000);

    // Requester drops req after 3 beats; grant held until all 8 return
    ic_req = 1'b1;
    tick();
    chk("drop_grant", ic_grant, 1'b1);
    beats(3, 0, 1'b0);
    ic_req = 1'b0;
    #1 chk("drop_held", ic_grant, 1'b1);
    chk("drop_enable", mem_enable, 1'b0);
    beats(4, 3, 1'b0);
    chk("drop_still_held", ic_grant, 1'b1);
    beats(1, 7, 1'b0);
    chk("drop_done", ic_grant, 1'b0);

    // Async reset mid-fill
    ic_req = 1'b1;
    tick();
    chk("rstmid_grant", ic_grant, 1'b1);
    beats(2, 0, 1'b0);
    rst_n = 1'b0;
    #1 chk("rstmid_ic_grant", ic_grant, 1'b0);
    chk("rstmid_enable", mem_enable, 1'b0);
    chk("rstmid_wr", mem_wr, 1'b0);
    ic_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    mem_data_valid = 1'b1; mem_data_out = 16'hDEAD;
    #1 chk("stray_ic_dv", ic_data_valid, 1'b0);
    chk("stray_dc_dv", dc_data_valid, 1'b0);
    tick();
    mem_data_valid = 1'b0;

    // Full fill after the aborted one still counts exactly 8 beats
    ic_req = 1'b1;
    tick();
    chk("refill_grant", ic_grant, 1'b1);
    beats(7, 0, 1'b0);
    chk("refill_held", ic_grant, 1'b1);
    beats(1, 7, 1'b0);
    chk("refill_done", ic_grant, 1'b0);
    ic_req = 1'b0;
    tick();
    tick();

    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
